// File: rtl/irq_enc8x3.sv
// Eight-source interrupt cause encoder: latches request pulses, masks them and
// presents the highest-priority pending source as a held code with valid/ack.
module irq_enc8x3 #(
  parameter bit PRIO_HIGH = 1'b0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] req_i,
  input  logic [7:0] mask_i,
  input  logic       ack_i,
  output logic       valid_o,
  output logic [2:0] code_o,
  output logic [7:0] grant_o,
  output logic [7:0] pend_o
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e     state_q;
  logic       valid_q;
  logic [2:0] code_q;
  logic [7:0] pend_q;
  logic [7:0] pend_d;

  logic [7:0] elig;
  logic [7:0] clr;
  logic [2:0] sel_idx;
  logic       ack_acc;

  assign ack_acc = (state_q == HOLD) & ack_i;
  assign clr     = ack_acc ? (8'h01 << code_q) : 8'h00;
  // A new pulse on the acknowledged source outranks its clear.
  assign pend_d  = (pend_q & ~clr) | req_i;
  assign elig    = (pend_q | req_i) & mask_i;

  always_comb begin
    sel_idx = 3'd0;
    if (PRIO_HIGH) begin
      for (int i = 0; i < 8; i++) begin
        if (elig[i]) sel_idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (elig[i]) sel_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      code_q  <= 3'd0;
      pend_q  <= 8'h00;
    end else begin
      pend_q <= pend_d;
      case (state_q)
        IDLE: begin
          if (|elig) begin
            code_q  <= sel_idx;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          // Code stays frozen until acknowledged, even if its source is masked.
          if (ack_i) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign valid_o = valid_q;
  assign code_o  = code_q;
  assign pend_o  = pend_q;
  assign grant_o = valid_q ? (8'h01 << code_q) : 8'h00;

endmodule

// File: doc/irq_enc8x3.md
Name: irq_enc8x3

Overview:
- Eight-input interrupt/exception cause encoder; the encode direction of the processor's 3-to-8 select decoders.
- Captures single-cycle request pulses into a pending register and masks them.
- Selects the highest-priority pending source and presents it as a registered 3-bit cause code with a valid/ack handshake.
- Sits between the interrupt/exception sources and the pipeline's exception/EPC control logic. The code is held stable until the control logic acknowledges it.

Parameters:
- PRIO_HIGH, 0: priority order. 0 = index 0 highest (7 lowest); 1 = index 7 highest (0 lowest).

Ports:
- clk      input   1  system clock, rising-edge
- reset    input   1  synchronous, active-high reset
- req      input   8  request pulses; bit i set for any number of cycles marks source i pending
- mask     input   8  enable per source; 1 = eligible for selection
- ack      input   1  consumer accepts current code; honoured only while valid=1
- valid    output  1  code/grant hold a selected cause
- code     output  3  binary index of the selected source
- grant    output  8  one-hot decode of code when valid=1, else 8'h00
- pend     output  8  pending register, unmasked view

Behaviour:
- Single clock domain. Every register updates on the rising edge of clk. There are no combinational paths from inputs to valid or code.
- Reset, synchronous, active-high. On an edge with reset=1:
  - pend=8'h00, valid=0, code=3'd0, state=IDLE.
  - grant=8'h00.
  - req, mask and ack in that cycle are ignored.
  - Reset overrides all other activity, including in HOLD, which drops the held code.
- Pending capture, every non-reset edge: pend <= (pend & ~clr) | req.
  - clr is one-hot of code when an accepted ack occurs this cycle, else 0.
  - req takes precedence over clr, so a new pulse on the acknowledged source in the ack cycle keeps it pending.
- Eligible set: elig = (pend | req) & mask. Current-cycle requests are visible to selection.
- Selection: the priority encode of elig per PRIO_HIGH.
  - With PRIO_HIGH=0 it picks the lowest set index.
  - With PRIO_HIGH=1 it picks the highest set index.
- FSM, two states:
  - IDLE, valid=0:
    - If elig != 0: code <= selected index, valid <= 1, go to HOLD.
    - Else stay in IDLE; code keeps its last value.
  - HOLD, valid=1:
    - code is frozen. Changes to mask, req, or the arrival of higher-priority requests do not alter code, and a now-masked source is not withdrawn.
    - When ack=1: clear pend[code] per the capture rule, valid <= 0, go to IDLE.
    - When ack=0: stay in HOLD.
- ack in IDLE is ignored and has no effect on pend.
- Latency and throughput:
  - Request pulse in cycle N, mask set, FSM in IDLE: valid=1 from cycle N+1.
  - After an accepted ack in cycle M: valid=0 in cycle M+1; the next grant can appear at M+2 at the earliest.
  - Peak rate is one cause every 2 cycles.
- grant is combinational from the valid and code registers only: grant = valid ? (8'h01 << code) : 8'h00.
- A masked source stays in pend indefinitely and is selected once unmasked while the FSM is in IDLE.

Test Plan:
1. Reset: assert reset with req=8'hFF, mask=8'hFF for 1 cycle -> valid=0, code=0, grant=00, pend=00. Deassert with req=0 -> valid stays 0.
2. Fixed priority and drain, PRIO_HIGH=0, mask=FF:
   - req=8'h24 for 1 cycle -> next cycle valid=1, code=2, grant=04, pend=24.
   - Hold ack=0 for 3 cycles -> outputs unchanged.
   - ack=1 -> next cycle valid=0, pend=20; following cycle valid=1, code=5, grant=20.
   - ack -> pend=00, valid=0.
3. Masking, mask=8'hFB, req=8'h24 -> code=5. Set mask=FF during HOLD -> code stays 5. ack -> then code=2.
4. Simultaneous ack and re-request: in HOLD with code=3, assert ack=1 and req=8'h08 in the same cycle -> pend[3] stays 1, valid=0 next cycle, then valid=1, code=3 again.
5. PRIO_HIGH=1 instance: req=8'h81 -> code=7 first; after ack -> code=0.
6. Reset mid-HOLD and stray ack:
   - ack=1 while valid=0 with pend=8'h10 and mask=00 -> pend stays 10.
   - Then set mask=FF, reach HOLD with code=4, assert reset -> next cycle valid=0, pend=00, grant=00.
